// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, decode handoff and redirect.
// The master modport is the prefetch queue; the slave modport is the surrounding pipeline/memory.
interface ifetch_queue_if #(
  parameter int AW = 16,
  parameter int IW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pcnext;
  logic          out_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc, out_pcnext,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc, out_pcnext,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues in-order fetches, buffers returned words with their PC,
// and flushes on redirect while discarding responses that were already in flight.
module ifetch_queue #(
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, outstanding_reg, drop_reg;
  logic [AW-1:0] fetch_pc_reg, resp_pc_reg;

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];

  logic [CW:0] in_use;
  logic        issue, enq, deq, discard;

  // Every in-flight request already owns a queue slot, so responses are never refused.
  assign in_use = {1'b0, count_reg} + {1'b0, outstanding_reg};

  always_comb begin
    bus.mem_req  = rst && !bus.redirect && (in_use < (CW+1)'(DEPTH));
    bus.mem_addr = fetch_pc_reg;
    issue        = bus.mem_req && bus.mem_gnt;
    discard      = bus.mem_rvalid && (drop_reg != '0);
    enq          = bus.mem_rvalid && (drop_reg == '0) && !bus.redirect;
    deq          = (count_reg != '0) && bus.out_ready && !bus.redirect;
  end

  always_comb begin
    bus.out_valid  = (count_reg != '0);
    bus.out_instr  = bus.out_valid ? instr_mem[head_reg] : '0;
    bus.out_pc     = bus.out_valid ? pc_mem[head_reg] : '0;
    bus.out_pcnext = bus.out_pc + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(issue) - CW'(bus.mem_rvalid);
      if (bus.redirect) begin
        // Everything still in flight after this cycle belongs to the abandoned path.
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
        fetch_pc_reg <= bus.redirect_pc;
        resp_pc_reg  <= bus.redirect_pc;
        drop_reg     <= outstanding_reg - CW'(bus.mem_rvalid);
      end else begin
        if (issue)   fetch_pc_reg <= fetch_pc_reg + AW'(1);
        if (discard) drop_reg     <= drop_reg - CW'(1);
        if (enq) begin
          tail_reg    <= tail_reg + PW'(1);
          resp_pc_reg <= resp_pc_reg + AW'(1);
        end
        if (deq) head_reg <= head_reg + PW'(1);
        count_reg <= count_reg + CW'(enq) - CW'(deq);
      end
    end
  end

  // Storage is only read when its slot is counted valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[tail_reg] <= bus.mem_rdata;
      pc_mem[tail_reg]    <= resp_pc_reg;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a fixed-latency in-order instruction memory model.
module tb_ifetch_queue;
  localparam int AW = 16;
  localparam int IW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lat = 1;
  int   cyc = 0;

  ifetch_queue_if #(.AW(AW), .IW(IW)) bus();

  ifetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model: grant sampled mid-cycle, response returned lat cycles after issue, in order.
  logic [AW-1:0] q_addr[$];
  int            q_due[$];
  logic          smp_issue, smp_rvalid;
  logic [AW-1:0] smp_addr;

  always @(negedge clk) begin
    smp_issue  = bus.mem_req & bus.mem_gnt;
    smp_addr   = bus.mem_addr;
    smp_rvalid = bus.mem_rvalid;
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (smp_rvalid && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (smp_issue) begin
        q_addr.push_back(smp_addr);
        q_due.push_back(cyc + lat);
      end
    end
    cyc++;
    if (rst && q_addr.size() > 0 && q_due[0] <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = word_of(q_addr[0]);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 right after reset release.
  task automatic apply_reset(input int l, input logic rdy);
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_gnt = 1'b1;
    bus.out_ready = rdy;
    lat = l;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_gnt = 1'b1;
    bus.out_ready = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mem: req=%b addr=%h expected req=0 addr=0000", bus.mem_req, bus.mem_addr);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out: valid=%b instr=%h expected valid=0 instr=0000", bus.out_valid, bus.out_instr);
    end
    n_checks++;
    if (bus.out_pc !== 16'h0000 || bus.out_pcnext !== 16'h0001) begin
      n_fail++; $display("FAIL reset_pc: pc=%h pcnext=%h expected 0000/0001", bus.out_pc, bus.out_pcnext);
    end
    $display("reset: req=%b addr=%h valid=%b pc=%h pcnext=%h", bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_pc, bus.out_pcnext);
  endtask

  task automatic test_stream();
    logic [AW-1:0] e;
    apply_reset(1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== AW'(k)) begin
        n_fail++; $display("FAIL stream_issue c%0d: req=%b addr=%h expected req=1 addr=%h", k, bus.mem_req, bus.mem_addr, AW'(k));
      end
      if (k >= 2) begin
        e = AW'(k - 2);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_instr !== word_of(e) || bus.out_pcnext !== e + 16'h1) begin
          n_fail++; $display("FAIL stream_out c%0d: valid=%b pc=%h instr=%h pcnext=%h expected pc=%h instr=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_pcnext, e, word_of(e));
        end
      end else begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_empty c%0d: valid=%b expected 0", k, bus.out_valid);
        end
      end
      $display("stream c%0d: addr=%h valid=%b pc=%h instr=%h", k, bus.mem_addr, bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_stall();
    int n_iss = 0;
    logic [AW-1:0] e;
    apply_reset(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (bus.mem_req && bus.mem_gnt) n_iss++;
    end
    n_checks++;
    if (n_iss != DEPTH) begin
      n_fail++; $display("FAIL stall_issues: got %0d expected %0d", n_iss, DEPTH);
    end
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin
      n_fail++; $display("FAIL stall_full: req=%b valid=%b pc=%h expected req=0 valid=1 pc=0000", bus.mem_req, bus.out_valid, bus.out_pc);
    end
    $display("stall: issues=%0d req=%b head_pc=%h", n_iss, bus.mem_req, bus.out_pc);
    for (int k = 10; k < 15; k++) begin
      next_cycle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      e = AW'(k - 10);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_instr !== word_of(e)) begin
        n_fail++; $display("FAIL stall_drain c%0d: valid=%b pc=%h instr=%h expected pc=%h instr=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, e, word_of(e));
      end
      if (k == 10) begin
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
          n_fail++; $display("FAIL stall_noreq c10: req=%b expected 0", bus.mem_req);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0004) begin
          n_fail++; $display("FAIL stall_resume c11: req=%b addr=%h expected req=1 addr=0004", bus.mem_req, bus.mem_addr);
        end
      end
      $display("drain c%0d: req=%b addr=%h pc=%h", k, bus.mem_req, bus.mem_addr, bus.out_pc);
    end
  endtask

  task automatic test_redirect_latency();
    logic [AW-1:0] e;
    apply_reset(3, 1'b1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) next_cycle();
      bus.redirect = (k == 3);
      bus.redirect_pc = 16'h0040;
      @(negedge clk);
      if (k == 3) begin
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
          n_fail++; $display("FAIL redir_req c3: req=%b expected 0", bus.mem_req);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040) begin
          n_fail++; $display("FAIL redir_addr c4: req=%b addr=%h expected req=1 addr=0040", bus.mem_req, bus.mem_addr);
        end
      end
      if (k >= 4 && k <= 7) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL redir_drop c%0d: valid=%b pc=%h expected valid=0", k, bus.out_valid, bus.out_pc);
        end
      end
      if (k >= 8) begin
        e = 16'h0040 + AW'(k - 8);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_instr !== word_of(e)) begin
          n_fail++; $display("FAIL redir_out c%0d: valid=%b pc=%h instr=%h expected pc=%h instr=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, e, word_of(e));
        end
      end
      $display("redirect c%0d: req=%b addr=%h rvalid=%b valid=%b pc=%h", k, bus.mem_req, bus.mem_addr, bus.mem_rvalid, bus.out_valid, bus.out_pc);
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset(1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      bus.redirect = (k == 2);
      bus.redirect_pc = 16'h0100;
      @(negedge clk);
      if (k == 2) begin
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.mem_rvalid !== 1'b1) begin
          n_fail++; $display("FAIL same_pre c2: req=%b valid=%b rvalid=%b expected 0/1/1", bus.mem_req, bus.out_valid, bus.mem_rvalid);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100) begin
          n_fail++; $display("FAIL same_flush c3: valid=%b req=%b addr=%h expected 0/1/0100", bus.out_valid, bus.mem_req, bus.mem_addr);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL same_empty c4: valid=%b pc=%h expected valid=0", bus.out_valid, bus.out_pc);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0100 || bus.out_instr !== word_of(16'h0100)) begin
          n_fail++; $display("FAIL same_out c5: valid=%b pc=%h instr=%h expected pc=0100 instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, word_of(16'h0100));
        end
      end
      $display("same-cycle c%0d: req=%b addr=%h valid=%b pc=%h", k, bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_pc);
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] e;
    apply_reset(3, 1'b1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) next_cycle();
      bus.redirect = (k == 1) || (k == 2);
      bus.redirect_pc = (k == 1) ? 16'h0100 : 16'h0200;
      @(negedge clk);
      if (k == 3) begin
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0200) begin
          n_fail++; $display("FAIL b2b_addr c3: req=%b addr=%h expected req=1 addr=0200", bus.mem_req, bus.mem_addr);
        end
      end
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_drop c%0d: valid=%b pc=%h expected valid=0", k, bus.out_valid, bus.out_pc);
        end
      end
      if (k >= 7) begin
        e = 16'h0200 + AW'(k - 7);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_instr !== word_of(e)) begin
          n_fail++; $display("FAIL b2b_out c%0d: valid=%b pc=%h instr=%h expected pc=%h instr=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, e, word_of(e));
        end
      end
      $display("back-to-back c%0d: req=%b addr=%h valid=%b pc=%h", k, bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_pc);
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_pc [3];
    logic [AW-1:0] exp_nx [3];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
    exp_nx[0] = 16'hFFFF; exp_nx[1] = 16'h0000; exp_nx[2] = 16'h0001;
    apply_reset(1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      bus.redirect = (k == 0);
      bus.redirect_pc = 16'hFFFE;
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFE) begin
          n_fail++; $display("FAIL wrap_addr c1: req=%b addr=%h expected req=1 addr=FFFE", bus.mem_req, bus.mem_addr);
        end
      end
      if (k >= 3) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[k-3] || bus.out_pcnext !== exp_nx[k-3] || bus.out_instr !== word_of(exp_pc[k-3])) begin
          n_fail++; $display("FAIL wrap_out c%0d: pc=%h pcnext=%h instr=%h expected pc=%h pcnext=%h", k, bus.out_pc, bus.out_pcnext, bus.out_instr, exp_pc[k-3], exp_nx[k-3]);
        end
      end
      $display("wrap c%0d: addr=%h valid=%b pc=%h pcnext=%h", k, bus.mem_addr, bus.out_valid, bus.out_pc, bus.out_pcnext);
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (k == 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin
          n_fail++; $display("FAIL arst_pre c4: valid=%b pc=%h expected valid=1 pc=0000", bus.out_valid, bus.out_pc);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0004 || bus.out_pc !== 16'h0001) begin
          n_fail++; $display("FAIL arst_pre c5: req=%b addr=%h pc=%h expected 1/0004/0001", bus.mem_req, bus.mem_addr, bus.out_pc);
        end
      end
    end
    // Assert reset away from any clock edge; outputs must change without a clock.
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_now: req=%b addr=%h valid=%b expected 0/0000/0", bus.mem_req, bus.mem_addr, bus.out_valid);
    end
    n_checks++;
    if (bus.out_instr !== 16'h0000 || bus.out_pc !== 16'h0000 || bus.out_pcnext !== 16'h0001) begin
      n_fail++; $display("FAIL arst_out: instr=%h pc=%h pcnext=%h expected 0000/0000/0001", bus.out_instr, bus.out_pc, bus.out_pcnext);
    end
    $display("async reset: req=%b addr=%h valid=%b pc=%h pcnext=%h", bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_pc, bus.out_pcnext);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin
          n_fail++; $display("FAIL arst_restart c0: req=%b addr=%h expected req=1 addr=0000", bus.mem_req, bus.mem_addr);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000 || bus.out_instr !== word_of(16'h0000)) begin
          n_fail++; $display("FAIL arst_first c4: valid=%b pc=%h instr=%h expected pc=0000 instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, word_of(16'h0000));
        end
      end
      $display("restart c%0d: req=%b addr=%h valid=%b pc=%h", k, bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
